// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// oversampling constants and the baud divider calculation.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Tick indices within one 16-tick bit period.
  localparam logic [3:0] TICK_EARLY = 4'd7;
  localparam logic [3:0] TICK_MID   = 4'd8;
  localparam logic [3:0] TICK_LATE  = 4'd9;
  localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_e;

  // Clock cycles per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int div;
    div = clk_hz / (OVERSAMPLE * baud);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, extra pointer bit for full/empty,
// drops writes on full unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overrun;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_rd_en && !o_empty;
  assign w_push  = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_overrun <= i_wr_en && o_full && !w_pop;
    end
  end

  // NOTE: storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 2-of-3 majority per bit, receive FIFO.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int              DIV       = calc_div(CLK_HZ, BAUD);
  localparam int              DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_rx_prev;
  logic [1:0]       r_flush;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [1:0]       r_samp;
  logic [2:0]       r_bit_cnt;
  logic             r_stop_cnt;
  logic [7:0]       r_shift;
  logic             r_wr_en;
  logic             r_frame_err;
  logic             w_rx;
  logic             w_fall;
  logic             w_start;
  logic             w_tick;
  logic             w_mid;
  logic             w_end;
  logic             w_bit;
  logic             w_capture;
  logic             w_wr_d;
  logic             w_frame_err_d;
  logic             w_fifo_empty;
  logic             w_fifo_full;

  // The flush counter ignores edges until the synchroniser holds real line values,
  // so releasing reset onto a low line does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
      r_flush   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= r_sync[1];
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
    end
  end

  assign w_rx    = r_sync[1];
  assign w_fall  = (r_flush == 2'd3) && r_rx_prev && !w_rx;
  assign w_start = (r_state == IDLE) && w_fall;
  assign w_tick  = (r_div_cnt == DIV_LAST);
  assign w_mid   = w_tick && (r_tick_cnt == TICK_LATE);
  assign w_end   = w_tick && (r_tick_cnt == TICK_LAST);
  assign w_bit   = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

`ifdef UART_RX_PARITY_EN
  logic w_par_bad;
  logic r_parity_err;
  assign w_par_bad = w_bit ^ (^r_shift) ^ PARITY_ODD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_state_nxt = START;
      START: begin
        if (w_tick && (r_tick_cnt == TICK_MID) && w_rx) w_state_nxt = IDLE;
        else if (w_end)                                  w_state_nxt = DATA;
      end
      DATA: begin
`ifdef UART_RX_PARITY_EN
        if (w_end && (r_bit_cnt == DATA_LAST)) w_state_nxt = PARITY;
`else
        if (w_end && (r_bit_cnt == DATA_LAST)) w_state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_mid && w_par_bad) w_state_nxt = IDLE;
        else if (w_end)         w_state_nxt = STOP;
      end
`endif
      STOP:    if (w_mid && (!w_bit || (r_stop_cnt == STOP_LAST))) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_capture     = (r_state == DATA) && w_mid;
    w_frame_err_d = (r_state == STOP) && w_mid && !w_bit;
    w_wr_d        = (r_state == STOP) && w_mid && w_bit && (r_stop_cnt == STOP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_tick_cnt  <= 4'd0;
      r_samp      <= 2'b11;
      r_bit_cnt   <= 3'd0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= 8'd0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_d;
      r_frame_err <= w_frame_err_d;
      if (w_start || w_tick) r_div_cnt <= '0;
      else                   r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (w_start) begin
        r_tick_cnt <= 4'd0;
        r_bit_cnt  <= 3'd0;
        r_stop_cnt <= 1'b0;
        r_shift    <= 8'd0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if (r_tick_cnt == TICK_EARLY) r_samp[0] <= w_rx;
        if (r_tick_cnt == TICK_MID)   r_samp[1] <= w_rx;
        if (w_capture)                r_shift[r_bit_cnt] <= w_bit;
        if ((r_state == DATA) && w_end) r_bit_cnt  <= r_bit_cnt + 3'd1;
        if ((r_state == STOP) && w_end) r_stop_cnt <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= (r_state == PARITY) && w_mid && w_par_bad;
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (r_wr_en),
    .i_wr_data (r_shift),
    .i_rd_en   (rx_ready),
    .o_rd_data (rx_data),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full),
    .o_overrun (overrun_err)
  );

  assign rx_valid  = !w_fifo_empty;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1 (16 clocks per bit); parity cases
// are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int n_vec  = 0;
  int n_miss = 0;

  int         n_valid_cyc = 0;
  int         n_fe        = 0;
  int         n_oe        = 0;
  int         n_pe        = 0;
  logic [7:0] q_rx [$];

  uart_rx #(
    .CLK_HZ     (1843200),
    .BAUD       (115200),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge, away from where the DUT updates.
  always @(negedge clk) begin
    if (rx_valid) n_valid_cyc++;
    if (rx_valid && rx_ready) q_rx.push_back(rx_data);
    if (frame_err)   n_fe++;
    if (overrun_err) n_oe++;
    if (parity_err)  n_pe++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, optional parity (even, flipped on request), stop, idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored, parity not compiled in");
`endif
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int         s_valid, s_fe, s_oe, s_pe, s_q;
  logic [7:0] exp_b;

  task automatic snap();
    s_valid = n_valid_cyc;
    s_fe    = n_fe;
    s_oe    = n_oe;
    s_pe    = n_pe;
    s_q     = q_rx.size();
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check("rst_rx_data",  32'(rx_data),     32'h00);
    check("rst_rx_valid", 32'(rx_valid),    32'h0);
    check("rst_frame",    32'(frame_err),   32'h0);
    check("rst_overrun",  32'(overrun_err), 32'h0);
    check("rst_parity",   32'(parity_err),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);

    // Basic byte with consumer always ready.
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    check("a5_count",   32'(q_rx.size() - s_q),      32'd1);
    check("a5_data",    32'(q_rx[q_rx.size()-1]),    32'hA5);
    check("a5_valid1",  32'(n_valid_cyc - s_valid),  32'd1);
    check("a5_no_fe",   32'(n_fe - s_fe),            32'd0);
    check("a5_no_oe",   32'(n_oe - s_oe),            32'd0);
    check("a5_no_pe",   32'(n_pe - s_pe),            32'd0);

    // Short low glitch must be rejected as a false start.
    snap();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * BIT_CYC);
    check("glitch_no_valid", 32'(n_valid_cyc - s_valid), 32'd0);
    check("glitch_no_fe",    32'(n_fe - s_fe),           32'd0);
    check("glitch_no_oe",    32'(n_oe - s_oe),           32'd0);
    check("glitch_no_pe",    32'(n_pe - s_pe),           32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(8);
    check("post_glitch_count", 32'(q_rx.size() - s_q),   32'd1);
    check("post_glitch_data",  32'(q_rx[q_rx.size()-1]), 32'h5A);

    // Bad stop bit.
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(8);
    check("fe_pulse",    32'(n_fe - s_fe),           32'd1);
    check("fe_no_valid", 32'(n_valid_cyc - s_valid), 32'd0);
    check("fe_rx_data",  32'(rx_data),               32'h00);

    // Overrun: fill a 4-deep FIFO, the fifth byte is dropped.
    rx_ready = 1'b0;
    snap();
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0);
    idle(8);
    check("full_no_oe",  32'(n_oe - s_oe), 32'd0);
    check("full_valid",  32'(rx_valid),    32'h1);
    send_frame(8'h05, 1'b1, 1'b0);
    idle(8);
    check("oe_pulse",    32'(n_oe - s_oe), 32'd1);
    check("oe_head",     32'(rx_data),     32'h01);
    check("oe_no_fe",    32'(n_fe - s_fe), 32'd0);
    snap();
    rx_ready = 1'b1;
    idle(10);
    rx_ready = 1'b0;
    check("drain_count", 32'(q_rx.size() - s_q), 32'd4);
    for (int k = 0; k < 4; k++) begin
      exp_b = 8'(k + 1);
      if (s_q + k < q_rx.size()) check($sformatf("drain_%0d", k), 32'(q_rx[s_q+k]), 32'(exp_b));
      else                       check($sformatf("drain_%0d", k), 32'hFFFF_FFFF, 32'(exp_b));
    end
    check("drain_empty", 32'(rx_valid), 32'h0);

    // Reset in the middle of 0x55 (during data bit 3), then 0x99.
    rx_ready = 1'b1;
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h55 >> i));
    rx = 1'b0;
    idle(8);
    rst_n = 1'b0;
    idle(5);
    check("midrst_valid", 32'(rx_valid), 32'h0);
    rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2 * BIT_CYC);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(8);
    check("midrst_count", 32'(q_rx.size() - s_q), 32'd1);
    check("midrst_data",  32'(q_rx[q_rx.size()-1]), 32'h99);
    check("midrst_no_fe", 32'(n_fe - s_fe), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_bad_pulse",    32'(n_pe - s_pe),           32'd1);
    check("par_bad_no_valid", 32'(n_valid_cyc - s_valid), 32'd0);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    check("par_ok_no_pe", 32'(n_pe - s_pe),           32'd0);
    check("par_ok_count", 32'(q_rx.size() - s_q),     32'd1);
    check("par_ok_data",  32'(q_rx[q_rx.size()-1]),   32'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
